rand_rect_cmd_gen: RTL and testbench

Consumes the 12-bit pseudo-random word stream from the LFSR stage and assembles random rectangle draw commands for the GPU draw engine. Each command carries position, size and RGB444 colour, and is offered downstream on a valid/ready handshake. Samples are taken every STRIDE cycles so that successive fields are decorrelated. Position values outside the screen are rejected and re-sampled, and sizes are clipped to the screen edge.

---
 rtl/rand_rect_cmd_gen.sv | 123 ++++++++++++
 tb/tb_rand_rect_cmd_gen.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rand_rect_cmd_gen.sv
// Random rectangle command generator: samples the LFSR word stream every STRIDE
// cycles into position/size/colour fields and offers a command on valid/ready.
`timescale 1ns/1ps
module rand_rect_cmd_gen #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int STRIDE = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] rand_num,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [9:0]  cmd_x,
  output logic [8:0]  cmd_y,
  output logic [6:0]  cmd_w,
  output logic [6:0]  cmd_h,
  output logic [11:0] cmd_color,
  output logic [15:0] cmd_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_GX, S_GY, S_GW, S_GH, S_GC, S_OUT
  } state_t;

  localparam int CW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [CW-1:0] LAST  = CW'(STRIDE - 1);
  localparam logic [10:0]   H_LIM = 11'(H_RES);
  localparam logic [10:0]   V_LIM = 11'(V_RES);

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           valid_n;
  logic [9:0]     x_n;
  logic [8:0]     y_n;
  logic [6:0]     w_n, h_n;
  logic [11:0]    color_n;
  logic [15:0]    count_n;

  logic           gather, sample;
  logic [10:0]    size_raw, w_room, h_room;

  assign gather   = (state != S_IDLE) && (state != S_OUT);
  assign sample   = gather && (cnt == LAST);
  // Size candidate and remaining room to the screen edge, compared at 11 bits.
  assign size_raw = {5'b0, rand_num[5:0]} + 11'd1;
  assign w_room   = H_LIM - {1'b0, cmd_x};
  assign h_room   = V_LIM - {2'b0, cmd_y};

  always_comb begin
    state_n = state;
    valid_n = cmd_valid;
    x_n     = cmd_x;
    y_n     = cmd_y;
    w_n     = cmd_w;
    h_n     = cmd_h;
    color_n = cmd_color;
    count_n = cmd_count;
    // Counter restarts after every sample (accept or reject) and on abort.
    cnt_n   = (gather && enable && !sample) ? cnt + CW'(1) : '0;

    if (gather && !enable) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (enable) state_n = S_GX;
        S_GX: if (sample && ({1'b0, rand_num[9:0]} < H_LIM)) begin
          x_n     = rand_num[9:0];
          state_n = S_GY;
        end
        S_GY: if (sample && ({2'b0, rand_num[8:0]} < V_LIM)) begin
          y_n     = rand_num[8:0];
          state_n = S_GW;
        end
        S_GW: if (sample) begin
          w_n     = (size_raw <= w_room) ? size_raw[6:0] : w_room[6:0];
          state_n = S_GH;
        end
        S_GH: if (sample) begin
          h_n     = (size_raw <= h_room) ? size_raw[6:0] : h_room[6:0];
          state_n = S_GC;
        end
        S_GC: if (sample) begin
          color_n = rand_num;
          valid_n = 1'b1;
          state_n = S_OUT;
        end
        S_OUT: if (cmd_ready) begin
          valid_n = 1'b0;
          count_n = cmd_count + 16'd1;
          state_n = enable ? S_GX : S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cmd_valid <= 1'b0;
      cmd_x     <= '0;
      cmd_y     <= '0;
      cmd_w     <= '0;
      cmd_h     <= '0;
      cmd_color <= '0;
      cmd_count <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cmd_valid <= valid_n;
      cmd_x     <= x_n;
      cmd_y     <= y_n;
      cmd_w     <= w_n;
      cmd_h     <= h_n;
      cmd_color <= color_n;
      cmd_count <= count_n;
    end
  end

endmodule

// File: tb/tb_rand_rect_cmd_gen.sv
// Bench for rand_rect_cmd_gen: scripted and random word streams checked against
// a stream-parsing reference model; a second instance covers STRIDE=12.
`timescale 1ns/1ps
module tb_rand_rect_cmd_gen;

  logic        clk = 1'b0;
  logic        reset, enable, cmd_ready, en12, rdy12;
  logic [11:0] rand_num;

  logic        cmd_valid, v12;
  logic [9:0]  cmd_x, x12;
  logic [8:0]  cmd_y, y12;
  logic [6:0]  cmd_w, cmd_h, w12, h12;
  logic [11:0] cmd_color, c12;
  logic [15:0] cmd_count, n12;

  rand_rect_cmd_gen #(.H_RES(640), .V_RES(480), .STRIDE(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rand_num(rand_num),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color), .cmd_count(cmd_count));

  rand_rect_cmd_gen #(.H_RES(640), .V_RES(480), .STRIDE(12)) u12 (
    .clk(clk), .reset(reset), .enable(en12), .rand_num(rand_num),
    .cmd_ready(rdy12), .cmd_valid(v12), .cmd_x(x12), .cmd_y(y12),
    .cmd_w(w12), .cmd_h(h12), .cmd_color(c12), .cmd_count(n12));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_count = 0;
  int lat;

  logic [11:0] script_q[$];
  logic [11:0] hist_q[$];

  int          m_x, m_y, m_w, m_h, m_lat;
  logic [11:0] m_c;

  // Reference: parse the sampled word stream into a command by the field rules.
  task automatic model_cmd();
    int i = 0;
    int n = hist_q.size();
    int raw;
    m_lat = -2;
    while (i < n && int'(hist_q[i][9:0]) >= 640) i++;
    if (i >= n) return;
    m_x = int'(hist_q[i][9:0]); i++;
    while (i < n && int'(hist_q[i][8:0]) >= 480) i++;
    if (i + 3 > n) return;
    m_y = int'(hist_q[i][8:0]); i++;
    raw = int'(hist_q[i][5:0]) + 1;
    m_w = (raw < 640 - m_x) ? raw : 640 - m_x;
    raw = int'(hist_q[i+1][5:0]) + 1;
    m_h = (raw < 480 - m_y) ? raw : 480 - m_y;
    m_c = hist_q[i+2];
    m_lat = i + 3;
  endtask

  // Drive one word per cycle (script first, then random) until cmd_valid rises.
  task automatic collect(input int budget, output int l);
    hist_q.delete();
    l = -1;
    for (int c = 1; c <= budget; c++) begin
      rand_num = (script_q.size() != 0) ? script_q.pop_front() : 12'($urandom);
      hist_q.push_back(rand_num);
      @(posedge clk); #1;
      if (cmd_valid) begin
        l = c;
        break;
      end
    end
  endtask

  task automatic start_enable();
    enable = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic handshake();
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    exp_count++;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; cmd_ready = 1'b1; en12 = 1'b1; rdy12 = 1'b1;
    rand_num = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b x=%0d y=%0d w=%0d h=%0d c=%h n=%0d, want all 0",
               cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_count);
    end
    checks++;
    if (v12 !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid12: got %b want 0", v12);
    end
    enable = 1'b0; cmd_ready = 1'b0; en12 = 1'b0; rdy12 = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    start_enable();
    script_q = '{12'h064, 12'h032, 12'h00F, 12'h007, 12'hF80};
    collect(20, lat);
    checks++;
    if (lat !== 5) begin
      failures++;
      $display("FAIL basic_latency: got %0d want 5", lat);
    end
    checks++;
    if ({cmd_x, cmd_y, cmd_w, cmd_h, cmd_color} !== {10'd100, 9'd50, 7'd16, 7'd8, 12'hF80}) begin
      failures++;
      $display("FAIL basic_fields: got x=%0d y=%0d w=%0d h=%0d c=%h want 100 50 16 8 f80",
               cmd_x, cmd_y, cmd_w, cmd_h, cmd_color);
    end
    enable = 1'b0;
    handshake();
    checks++;
    if ({cmd_valid, cmd_count} !== {1'b0, 16'd1}) begin
      failures++;
      $display("FAIL basic_handshake: got v=%b n=%0d want v=0 n=1", cmd_valid, cmd_count);
    end
  endtask

  task automatic test_reject_clip();
    start_enable();
    script_q = '{12'h3FF, 12'h27F, 12'h1FF, 12'h1DF, 12'h03F, 12'h03F, 12'hABC};
    collect(20, lat);
    checks++;
    if (lat !== 7) begin
      failures++;
      $display("FAIL clip_latency: got %0d want 7", lat);
    end
    checks++;
    if ({cmd_x, cmd_y, cmd_w, cmd_h, cmd_color} !== {10'd639, 9'd479, 7'd1, 7'd1, 12'hABC}) begin
      failures++;
      $display("FAIL clip_fields: got x=%0d y=%0d w=%0d h=%0d c=%h want 639 479 1 1 abc",
               cmd_x, cmd_y, cmd_w, cmd_h, cmd_color);
    end
    enable = 1'b0;
    handshake();
    checks++;
    if ({cmd_valid, cmd_count} !== {1'b0, 16'(exp_count)}) begin
      failures++;
      $display("FAIL clip_handshake: got v=%b n=%0d want v=0 n=%0d", cmd_valid, cmd_count, exp_count);
    end
  endtask

  task automatic test_back_to_back();
    start_enable();
    for (int k = 0; k < 8; k++) begin
      collect(60, lat);
      model_cmd();
      checks++;
      if (lat !== m_lat) begin
        failures++;
        $display("FAIL b2b_latency[%0d]: got %0d want %0d", k, lat, m_lat);
      end
      checks++;
      if ({cmd_x, cmd_y, cmd_w, cmd_h, cmd_color} !==
          {10'(m_x), 9'(m_y), 7'(m_w), 7'(m_h), m_c}) begin
        failures++;
        $display("FAIL b2b_fields[%0d]: got x=%0d y=%0d w=%0d h=%0d c=%h want %0d %0d %0d %0d %h",
                 k, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, m_x, m_y, m_w, m_h, m_c);
      end
      if (k == 7) enable = 1'b0;
      handshake();
      checks++;
      if ({cmd_valid, cmd_count} !== {1'b0, 16'(exp_count)}) begin
        failures++;
        $display("FAIL b2b_handshake[%0d]: got v=%b n=%0d want v=0 n=%0d",
                 k, cmd_valid, cmd_count, exp_count);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [44:0] held;
    logic        stable = 1'b1;
    start_enable();
    collect(60, lat);
    model_cmd();
    held = {10'(m_x), 9'(m_y), 7'(m_w), 7'(m_h), m_c};
    checks++;
    if ({cmd_x, cmd_y, cmd_w, cmd_h, cmd_color} !== held) begin
      failures++;
      $display("FAIL bp_fields: got %h want %h", {cmd_x, cmd_y, cmd_w, cmd_h, cmd_color}, held);
    end
    for (int i = 0; i < 10; i++) begin
      rand_num = 12'($urandom);
      @(posedge clk); #1;
      if (!cmd_valid || {cmd_x, cmd_y, cmd_w, cmd_h, cmd_color} !== held) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      failures++;
      $display("FAIL bp_hold: got stable=%b want 1 (v=%b fields=%h)", stable, cmd_valid,
               {cmd_x, cmd_y, cmd_w, cmd_h, cmd_color});
    end
    handshake();
    checks++;
    if ({cmd_valid, cmd_count} !== {1'b0, 16'(exp_count)}) begin
      failures++;
      $display("FAIL bp_handshake: got v=%b n=%0d want v=0 n=%0d", cmd_valid, cmd_count, exp_count);
    end
    script_q = '{12'h005, 12'h006, 12'h007, 12'h008, 12'h009};
    collect(20, lat);
    checks++;
    if (lat !== 5) begin
      failures++;
      $display("FAIL bp_next_latency: got %0d want 5", lat);
    end
    enable = 1'b0;
    handshake();
  endtask

  task automatic test_abort_reset();
    logic seen = 1'b0;
    logic held = 1'b1;
    // Abort in GY: partial command must be discarded.
    start_enable();
    rand_num = 12'h010;
    @(posedge clk); #1;
    enable = 1'b0;
    cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_num = 12'($urandom);
      @(posedge clk); #1;
      if (cmd_valid) seen = 1'b1;
    end
    cmd_ready = 1'b0;
    checks++;
    if ({seen, cmd_count} !== {1'b0, 16'(exp_count)}) begin
      failures++;
      $display("FAIL abort_gy: got seen_valid=%b n=%0d want 0 n=%0d", seen, cmd_count, exp_count);
    end
    // Enable dropped in OUT: command still delivered.
    start_enable();
    collect(60, lat);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_num = 12'($urandom);
      @(posedge clk); #1;
      if (!cmd_valid) held = 1'b0;
    end
    checks++;
    if (held !== 1'b1) begin
      failures++;
      $display("FAIL abort_out_hold: got held=%b want 1", held);
    end
    handshake();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cmd_valid, cmd_count} !== {1'b0, 16'(exp_count)}) begin
      failures++;
      $display("FAIL abort_out_deliver: got v=%b n=%0d want v=0 n=%0d", cmd_valid, cmd_count, exp_count);
    end
    // Asynchronous reset while a command is pending.
    start_enable();
    collect(60, lat);
    checks++;
    if (cmd_valid !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre_valid: got %b want 1", cmd_valid);
    end
    #2 reset = 1'b1;
    #1;
    exp_count = 0;
    checks++;
    if ({cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_count} !== '0) begin
      failures++;
      $display("FAIL areset_outputs: got v=%b x=%0d y=%0d w=%0d h=%0d c=%h n=%0d want all 0",
               cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_count);
    end
    enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_stride();
    rand_num = 12'h123;
    en12 = 1'b1;
    @(posedge clk); #1;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (v12) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat !== 60) begin
      failures++;
      $display("FAIL stride_latency: got %0d want 60", lat);
    end
    checks++;
    if ({x12, y12, w12, h12, c12} !== {10'h123, 9'h123, 7'd36, 7'd36, 12'h123}) begin
      failures++;
      $display("FAIL stride_fields: got x=%h y=%h w=%0d h=%0d c=%h want 123 123 36 36 123",
               x12, y12, w12, h12, c12);
    end
    en12 = 1'b0;
    rdy12 = 1'b1;
    @(posedge clk); #1;
    rdy12 = 1'b0;
    checks++;
    if ({v12, n12} !== {1'b0, 16'd1}) begin
      failures++;
      $display("FAIL stride_handshake: got v=%b n=%0d want v=0 n=1", v12, n12);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reject_clip();
    test_back_to_back();
    test_backpressure();
    test_abort_reset();
    test_stride();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
